// File: rtl/vending_machine.sv
// Eight-slot vending controller: coin or card payment, price and stock checks,
// dispense pulse, and greedy quarter/dime/nickel change breakdown.
module vending_machine (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  index,
    input  logic        paymentMethod,
    input  logic [8:0]  creditBalance,
    input  logic        nickel,
    input  logic        dime,
    input  logic        quarter,
    input  logic        dollar,
    input  logic [63:0] cost,
    input  logic        cancel,
    input  logic [23:0] currentInventory,
    output logic        dispensed,
    output logic [8:0]  change,
    output logic [4:0]  quart,
    output logic [4:0]  dim,
    output logic [4:0]  nick
);

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_COIN_SALE,
        ACT_CARD_SALE,
        ACT_REFUND
    } action_e;

    localparam logic [9:0] CREDIT_LIMIT = 10'd500;

    logic [7:0][2:0] stock;
    logic [8:0]      credit;
    logic            armed;
    logic [3:0]      prev_index;
    logic            prev_method;

    logic [7:0][7:0] price_tab;
    logic [2:0]      slot;
    logic [7:0]      price;
    logic            sellable;
    logic            selection_changed;
    logic            sale;
    logic [9:0]      coin_add;
    logic [9:0]      coin_total;
    action_e         action;
    logic [8:0]      credit_next;
    logic [8:0]      change_next;
    logic [8:0]      change_rem;

    assign price_tab = cost;
    assign slot      = index[2:0];
    assign price     = price_tab[slot];
    assign sellable  = !index[3] && (stock[slot] != 3'd0) && (price != 8'd0);

    assign selection_changed = (index != prev_index) || (paymentMethod != prev_method);

    assign coin_add   = (nickel  ? 10'd5   : 10'd0) + (dime   ? 10'd10  : 10'd0)
                      + (quarter ? 10'd25  : 10'd0) + (dollar ? 10'd100 : 10'd0);
    assign coin_total = {1'b0, credit} + coin_add;

    assign sale = (action == ACT_COIN_SALE) || (action == ACT_CARD_SALE);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        action      = ACT_IDLE;
        credit_next = credit;
        change_next = change;

        // A sale outranks a refund; card mode never touches coin credit.
        if (paymentMethod) begin
            if (armed && sellable && (creditBalance >= {1'b0, price}))
                action = ACT_CARD_SALE;
        end else if (sellable && (credit >= {1'b0, price})) begin
            action = ACT_COIN_SALE;
        end else if (cancel && (credit != 9'd0)) begin
            action = ACT_REFUND;
        end

        unique case (action)
            ACT_COIN_SALE: begin
                change_next = credit - {1'b0, price};
                credit_next = 9'd0;
            end
            ACT_CARD_SALE: begin
                change_next = 9'd0;
            end
            ACT_REFUND: begin
                change_next = credit;
                credit_next = 9'd0;
            end
            default: begin
                // Coins that would push credit past the limit are rejected as a group.
                if (!paymentMethod && (coin_total <= CREDIT_LIMIT))
                    credit_next = coin_total[8:0];
            end
        endcase

        change_rem = change_next % 9'd25;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the stock table is a small register file that is deliberately reloaded on reset from the inventory bus.
            stock       <= currentInventory;
            credit      <= 9'd0;
            armed       <= 1'b1;
            prev_index  <= index;
            prev_method <= paymentMethod;
            dispensed   <= 1'b0;
            change      <= 9'd0;
            quart       <= 5'd0;
            dim         <= 5'd0;
            nick        <= 5'd0;
        end else begin
            credit      <= credit_next;
            prev_index  <= index;
            prev_method <= paymentMethod;
            dispensed   <= sale;

            if (sale) begin
                armed       <= 1'b0;
                stock[slot] <= stock[slot] - 3'd1;
            end else if (selection_changed) begin
                armed <= 1'b1;
            end

            if (action != ACT_IDLE) begin
                change <= change_next;
                quart  <= 5'(change_next / 9'd25);
                dim    <= 5'(change_rem / 9'd10);
                nick   <= 5'((change_rem % 9'd10) / 9'd5);
            end
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_vending_machine;

    logic        clk;
    logic        rst;
    logic [3:0]  index;
    logic        paymentMethod;
    logic [8:0]  creditBalance;
    logic        nickel, dime, quarter, dollar;
    logic [63:0] cost;
    logic        cancel;
    logic [23:0] currentInventory;
    logic        dispensed;
    logic [8:0]  change;
    logic [4:0]  quart, dim, nick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, plain integers.
    int m_stock[8];
    int m_credit;
    bit m_armed;
    int m_prev_index;
    int m_prev_method;
    bit m_disp;
    int m_change;
    bit model_valid = 1'b0;
    int rand_sales = 0;

    vending_machine dut (
        .clk(clk), .rst(rst), .index(index), .paymentMethod(paymentMethod),
        .creditBalance(creditBalance), .nickel(nickel), .dime(dime),
        .quarter(quarter), .dollar(dollar), .cost(cost), .cancel(cancel),
        .currentInventory(currentInventory), .dispensed(dispensed),
        .change(change), .quart(quart), .dim(dim), .nick(nick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Greedy coin split done by repeated subtraction.
    task automatic breakdown(input int c, output int q, output int d, output int n);
        q = 0; d = 0; n = 0;
        while (c >= 25) begin c -= 25; q++; end
        while (c >= 10) begin c -= 10; d++; end
        while (c >= 5)  begin c -= 5;  n++; end
    endtask

    task automatic model_step();
        int idx, price, add;
        bit sellable, changed;
        if (!rst) begin
            for (int s = 0; s < 8; s++) m_stock[s] = int'((currentInventory >> (3 * s)) & 24'h7);
            m_credit      = 0;
            m_armed       = 1'b1;
            m_prev_index  = int'(index);
            m_prev_method = int'(paymentMethod);
            m_disp        = 1'b0;
            m_change      = 0;
            model_valid   = 1'b1;
            return;
        end
        if (!model_valid) return;
        idx      = int'(index);
        price    = (idx < 8) ? int'((cost >> (8 * idx)) & 64'hFF) : 0;
        sellable = (idx < 8) ? (price != 0 && m_stock[idx] > 0) : 1'b0;
        changed  = (idx != m_prev_index) || (int'(paymentMethod) != m_prev_method);
        m_disp   = 1'b0;
        if (paymentMethod) begin
            if (m_armed && sellable && int'(creditBalance) >= price) begin
                m_disp = 1'b1;
                m_change = 0;
                m_stock[idx]--;
            end
        end else if (sellable && m_credit >= price) begin
            m_disp = 1'b1;
            m_change = m_credit - price;
            m_credit = 0;
            m_stock[idx]--;
        end else if (cancel && m_credit > 0) begin
            m_change = m_credit;
            m_credit = 0;
        end else begin
            add = 5 * nickel + 10 * dime + 25 * quarter + 100 * dollar;
            if (m_credit + add <= 500) m_credit += add;
        end
        if (m_disp) m_armed = 1'b0;
        else if (changed) m_armed = 1'b1;
        m_prev_index  = idx;
        m_prev_method = int'(paymentMethod);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: outputs sampled on the falling edge.
    initial begin
        int q, d, n;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                breakdown(m_change, q, d, n);
                check("dispensed", dispensed, m_disp);
                check("change", change, m_change);
                check("quart", quart, q);
                check("dim", dim, d);
                check("nick", nick, n);
                if (m_disp && rst) rand_sales++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int disp, input int chg, input int q, input int d, input int n);
        check({tag, "_disp"}, dispensed, disp);
        check({tag, "_change"}, change, chg);
        check({tag, "_quart"}, quart, q);
        check({tag, "_dim"}, dim, d);
        check({tag, "_nick"}, nick, n);
    endtask

    task automatic clear_coins();
        nickel = 0; dime = 0; quarter = 0; dollar = 0;
    endtask

    initial begin
        int pulses;
        rst = 0; index = 0; paymentMethod = 0; creditBalance = 0;
        clear_coins(); cancel = 0;
        cost = {8{8'd100}};
        currentInventory = {8{3'd4}};
        step(); step();
        rst = 1;
        step();
        expect_out("reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_disp", dispensed, 0);
        end

        // Card purchase, one per arming.
        paymentMethod = 1; index = 2; creditBalance = 200;
        step();
        expect_out("card_buy", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("card_hold_disp", dispensed, 0);
        end
        index = 3;
        step();
        check("card_rearm_disp", dispensed, 0);
        step();
        check("card_slot3_disp", dispensed, 1);
        step();

        // Slot 2 has three items left: five re-armings yield exactly three sales.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            index = 8; step(); pulses += dispensed; step(); pulses += dispensed;
            index = 2; step(); pulses += dispensed; step(); pulses += dispensed;
        end
        check("card_drain_pulses", pulses, 3);

        // Coin purchase: one dollar, dispense two edges after the coin cycle.
        paymentMethod = 0; index = 3;
        step();
        dollar = 1; step(); check("dollar_wait_disp", dispensed, 0);
        clear_coins(); step();
        expect_out("dollar_buy", 1, 0, 0, 0, 0);
        step(); check("dollar_after_disp", dispensed, 0);

        // Nickel and dollar together.
        nickel = 1; dollar = 1; step(); check("combo_wait_disp", dispensed, 0);
        clear_coins(); step();
        expect_out("combo_buy", 1, 5, 0, 0, 1);

        // Partial credit then cancel.
        quarter = 1; step(); check("q_disp", dispensed, 0);
        clear_coins(); dime = 1; step(); check("d_disp", dispensed, 0);
        clear_coins(); nickel = 1; step(); check("n_disp", dispensed, 0);
        clear_coins(); cancel = 1; step();
        expect_out("refund", 0, 40, 1, 1, 1);
        cancel = 0; step();
        expect_out("refund_hold", 0, 40, 1, 1, 1);
        dollar = 1; step();
        clear_coins(); step();
        expect_out("post_refund_buy", 1, 0, 0, 0, 0);

        // Slot 3 now empty: credit is kept and moves to another slot.
        dollar = 1; step();
        clear_coins(); step(); check("empty_disp_a", dispensed, 0);
        step(); check("empty_disp_b", dispensed, 0);
        index = 9; quarter = 1; step(); check("bad_index_disp_a", dispensed, 0);
        clear_coins(); step(); check("bad_index_disp_b", dispensed, 0);
        index = 4; step();
        expect_out("retained_buy", 1, 25, 1, 0, 0);

        // Credit ceiling: the nickel past 500 is rejected.
        index = 9; step();
        for (int i = 0; i < 5; i++) begin
            dollar = 1; step();
        end
        clear_coins(); nickel = 1; step();
        clear_coins(); index = 5; step();
        expect_out("ceiling_buy", 1, 400, 16, 0, 0);
        step();

        // Randomized traffic against the model.
        rand_sales = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 299) == 0 || cyc == 0) begin
                currentInventory = 24'($urandom);
                for (int s = 0; s < 8; s++)
                    cost[8 * s +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(5, 150));
                rst = 0;
            end else begin
                rst = 1;
            end
            if ($urandom_range(0, 19) == 0) index = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) paymentMethod = ~paymentMethod;
            if ($urandom_range(0, 9) == 0) creditBalance = 9'($urandom_range(0, 511));
            nickel  = ($urandom_range(0, 5) == 0);
            dime    = ($urandom_range(0, 5) == 0);
            quarter = ($urandom_range(0, 5) == 0);
            dollar  = ($urandom_range(0, 7) == 0);
            cancel  = ($urandom_range(0, 24) == 0);
            step();
        end
        rst = 1; clear_coins(); cancel = 0;
        step(); step();
        check("random_sales_seen", (rand_sales > 0) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
